// File: rtl/alu_op_decoder.sv
`timescale 1ns/1ps
// alu_op_decoder
// Registered RV32I instruction decoder. It produces the ALU control bundle
// (op, shift controls, immediate, operand select, register fields and
// writeback enable) and sits between instruction fetch and execute.
// Decoded bundles pass through a two-entry buffer. The main entry drives the
// outputs, and the skid entry absorbs one accept while main is stalled.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/in_ready/instr      instruction input handshake
//   flush           discard every buffered bundle
//   out_valid/out_ready          decoded bundle handshake
//   op, shifter_size, shamt_from_rs2, imm, imm_sel,
//   rs1_addr, rs2_addr, rd_addr, rd_we, is_branch, illegal   decoded bundle
//
// Configuration macro: DECODER_ILLEGAL_TRAP_EN
//   defined   - an illegal encoding is delivered in order with illegal=1
//   undefined - illegal is tied 0 and an illegal encoding decodes as a NOP
module alu_op_decoder #(
  parameter int WIDTH = 32,
  parameter int OP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP-1:0]    op,
  output logic [4:0]       shifter_size,
  output logic             shamt_from_rs2,
  output logic [WIDTH-1:0] imm,
  output logic             imm_sel,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             is_branch,
  output logic             illegal
);

  localparam logic [OP-1:0] OP_ADD = OP'(0);
  localparam logic [OP-1:0] OP_SUB = OP'(1);
  localparam logic [OP-1:0] OP_SLL = OP'(2);
  localparam logic [OP-1:0] OP_SRL = OP'(4);
  localparam logic [OP-1:0] OP_SRA = OP'(5);
  localparam logic [OP-1:0] OP_XOR = OP'(6);
  localparam logic [OP-1:0] OP_OR  = OP'(7);
  localparam logic [OP-1:0] OP_AND = OP'(8);
  localparam logic [OP-1:0] OP_BEQ = OP'(9);
  localparam logic [OP-1:0] OP_BNE = OP'(10);
  localparam logic [OP-1:0] OP_BLT = OP'(11);
  localparam logic [OP-1:0] OP_BGE = OP'(12);
  localparam logic [OP-1:0] OP_SLT = OP'(13);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OP-1:0]    op;
    logic [4:0]       shifter_size;
    logic             shamt_from_rs2;
    logic [WIDTH-1:0] imm;
    logic             imm_sel;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic             is_branch;
`ifdef DECODER_ILLEGAL_TRAP_EN
    logic             illegal;
`endif
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_shamt;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s     = {{(WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{(WIDTH-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
  assign imm_shamt = {{(WIDTH-5){1'b0}}, instr[24:20]};

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming instruction word.
  // ---------------------------------------------------------------------
  bundle_t dec;
  logic    bad;
  logic    alt_ok;  // funct7=0100000 is only meaningful for sub / sra(i)

  assign alt_ok = (funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101));

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a value held,
    // which would otherwise infer a latch.
    dec          = '0;
    bad          = 1'b0;
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rd_addr  = instr[11:7];

    case (opcode)
      OPC_R: begin
        dec.rd_we = 1'b1;
        if (funct7 != F7_BASE && !alt_ok) bad = 1'b1;
        case (funct3)
          3'b000: dec.op = funct7[5] ? OP_SUB : OP_ADD;
          3'b001: begin dec.op = OP_SLL; dec.shamt_from_rs2 = 1'b1; end
          3'b010: dec.op = OP_SLT;
          3'b100: dec.op = OP_XOR;
          3'b101: begin dec.op = funct7[5] ? OP_SRA : OP_SRL; dec.shamt_from_rs2 = 1'b1; end
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          default: bad = 1'b1;  // sltu
        endcase
      end

      OPC_I: begin
        dec.rd_we   = 1'b1;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_i;
        case (funct3)
          3'b000: dec.op = OP_ADD;
          3'b001: begin
            dec.op           = OP_SLL;
            dec.shifter_size = instr[24:20];
            dec.imm          = imm_shamt;
            if (funct7 != F7_BASE) bad = 1'b1;
          end
          3'b010: dec.op = OP_SLT;
          3'b100: dec.op = OP_XOR;
          3'b101: begin
            dec.op           = funct7[5] ? OP_SRA : OP_SRL;
            dec.shifter_size = instr[24:20];
            dec.imm          = imm_shamt;
            if (funct7 != F7_BASE && !alt_ok) bad = 1'b1;
          end
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          default: bad = 1'b1;  // sltiu
        endcase
      end

      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        case (funct3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          default: bad = 1'b1;  // bltu, bgeu and undefined codes
        endcase
      end

      OPC_LOAD: begin
        dec.op      = OP_ADD;
        dec.imm_sel = 1'b1;
        dec.rd_we   = 1'b1;
        dec.imm     = imm_i;
      end

      OPC_STORE: begin
        dec.op      = OP_ADD;
        dec.imm_sel = 1'b1;
        dec.imm     = imm_s;
      end

      default: bad = 1'b1;
    endcase

    // An illegal encoding must never write back, branch or shift; the
    // register fields are left as decoded since they are harmless.
    if (bad) begin
      dec.op             = OP_ADD;
      dec.rd_we          = 1'b0;
      dec.is_branch      = 1'b0;
      dec.imm_sel        = 1'b0;
      dec.imm            = '0;
      dec.shifter_size   = '0;
      dec.shamt_from_rs2 = 1'b0;
`ifdef DECODER_ILLEGAL_TRAP_EN
      dec.illegal        = 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Two-entry buffer: main drives the outputs, skid catches one accept
  // while main is stalled. in_ready depends only on registered state (and
  // reset), never on out_ready.
  // ---------------------------------------------------------------------
  bundle_t main_q, skid_q;
  logic    main_valid, skid_valid;
  logic    accept, main_free;

  assign in_ready  = !skid_valid && !rst;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever observed after
  // skid_valid is set, which also writes it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && !main_free && accept) skid_q <= dec;
  end

  assign out_valid      = main_valid;
  assign op             = main_q.op;
  assign shifter_size   = main_q.shifter_size;
  assign shamt_from_rs2 = main_q.shamt_from_rs2;
  assign imm            = main_q.imm;
  assign imm_sel        = main_q.imm_sel;
  assign rs1_addr       = main_q.rs1_addr;
  assign rs2_addr       = main_q.rs2_addr;
  assign rd_addr        = main_q.rd_addr;
  assign rd_we          = main_q.rd_we;
  assign is_branch      = main_q.is_branch;
`ifdef DECODER_ILLEGAL_TRAP_EN
  assign illegal        = main_q.illegal;
`else
  assign illegal        = 1'b0;
`endif

endmodule
